// File: rtl/pro12_led_pio_pkg.sv
// Shared constants for the LED PIO with blink and PWM: register offsets and
// the blink divider width.
package pro12_led_pio_pkg;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_RSVD      = 3'd1;
   localparam logic [2:0] ADDR_MODE      = 3'd2;
   localparam logic [2:0] ADDR_BLINK_DIV = 3'd3;
   localparam logic [2:0] ADDR_OUTSET    = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
   localparam logic [2:0] ADDR_BRIGHT    = 3'd6;
   localparam logic [2:0] ADDR_STATUS    = 3'd7;

   localparam int BLINK_DIV_W = 16;

endpackage

// File: rtl/pro12_led_pwm_gen.sv
// Free-running timebase: blink prescaler, blink half-period counter with phase,
// and PWM counter with a brightness shadow register reloaded at each wrap.
module pro12_led_pwm_gen
   import pro12_led_pio_pkg::*;
#(
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 50000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BLINK_DIV_W-1:0] blink_div,
   input  logic                   blink_div_wr,
   input  logic [PWM_BITS-1:0]    bright,
   output logic                   tick,
   output logic                   phase,
   output logic                   pwm_on
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]        PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]        PS_ONE   = PS_W'(1);
   localparam logic [BLINK_DIV_W-1:0] BLK_ONE  = BLINK_DIV_W'(1);
   localparam logic [PWM_BITS-1:0]    PWM_ONE  = PWM_BITS'(1);
   // Last count is all-ones minus one, so BRIGHT all-ones compares as always on.
   localparam logic [PWM_BITS-1:0]    PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

   logic [PS_W-1:0]        ps_cnt;
   logic [BLINK_DIV_W-1:0] blink_cnt;
   logic [PWM_BITS-1:0]    pwm_cnt;
   logic [PWM_BITS-1:0]    bright_active;

   assign tick   = (ps_cnt == PS_LAST);
   assign pwm_on = (pwm_cnt < bright_active);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps_cnt <= '0;
      end else if (tick) begin
         ps_cnt <= '0;
      end else begin
         ps_cnt <= ps_cnt + PS_ONE;
      end
   end

   // A zero divider parks the phase high; a divider write restarts the half-period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_div == '0) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_div_wr) begin
         blink_cnt <= '0;
      end else if (tick) begin
         if (blink_cnt == blink_div - BLK_ONE) begin
            blink_cnt <= '0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + BLK_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_cnt       <= '0;
         bright_active <= '1;
      end else if (pwm_cnt == PWM_LAST) begin
         pwm_cnt       <= '0;
         bright_active <= bright;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_ONE;
      end
   end

endmodule

// File: rtl/pro12_led_pio_pwm.sv
// Avalon-MM LED output port: register file, zero-latency read mux and the
// registered LED drive combining data, per-channel blink and global PWM.
module pro12_led_pio_pwm
   import pro12_led_pio_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int PWM_BITS = 8,
   parameter int PRESCALE = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic                   wr_en;
   logic [WIDTH-1:0]       data_reg;
   logic [WIDTH-1:0]       mode_reg;
   logic [BLINK_DIV_W-1:0] blink_div_reg;
   logic [PWM_BITS-1:0]    bright_reg;
   logic [WIDTH-1:0]       wdata;
   logic [WIDTH-1:0]       blink_mask;
   logic                   blink_div_wr;
   logic                   phase;
   logic                   pwm_on;
   logic                   tick_unused;
   logic                   unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[WIDTH-1:0];
   assign blink_div_wr = wr_en && (address == ADDR_BLINK_DIV);
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg      <= '0;
         mode_reg      <= '0;
         blink_div_reg <= '0;
         bright_reg    <= '1;
      end else if (wr_en) begin
         case (address)
            ADDR_DATA:      data_reg      <= wdata;
            ADDR_MODE:      mode_reg      <= wdata;
            ADDR_BLINK_DIV: blink_div_reg <= writedata[BLINK_DIV_W-1:0];
            ADDR_OUTSET:    data_reg      <= data_reg | wdata;
            ADDR_OUTCLEAR:  data_reg      <= data_reg & ~wdata;
            ADDR_BRIGHT:    bright_reg    <= writedata[PWM_BITS-1:0];
            default:        ;
         endcase
      end
   end

   pro12_led_pwm_gen #(
      .PWM_BITS (PWM_BITS),
      .PRESCALE (PRESCALE)
   ) u_pwm_gen (
      .clk          (clk),
      .reset        (reset),
      .blink_div    (blink_div_reg),
      .blink_div_wr (blink_div_wr),
      .bright       (bright_reg),
      .tick         (tick_unused),
      .phase        (phase),
      .pwm_on       (pwm_on)
   );

   // Read mux ignores chipselect; write-only and reserved offsets read zero.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:      readdata = 32'(data_reg);
         ADDR_MODE:      readdata = 32'(mode_reg);
         ADDR_BLINK_DIV: readdata = 32'(blink_div_reg);
         ADDR_BRIGHT:    readdata = 32'(bright_reg);
         ADDR_STATUS:    readdata = {30'd0, pwm_on, phase};
         default:        readdata = '0;
      endcase
   end

   assign blink_mask = phase ? '1 : ~mode_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_port <= '0;
      end else begin
         out_port <= data_reg & blink_mask & {WIDTH{pwm_on}};
      end
   end

endmodule

// File: tb/tb_pro12_led_pio_pwm.sv
// Bench for the LED PIO: directed scenarios plus random bus traffic, all
// checked against a cycle-level reference model driven from global time.
module tb_pro12_led_pio_pwm;

   localparam int WIDTH    = 8;
   localparam int PWM_BITS = 4;
   localparam int PRESCALE = 4;
   localparam int PERIOD   = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  m_data, m_mode, m_out;
   logic [15:0] m_div;
   logic [3:0]  m_bright;
   logic        m_phase;
   int          m_ticks, m_cyc, m_bact;

   always #5 clk = ~clk;

   pro12_led_pio_pwm #(
      .WIDTH    (WIDTH),
      .PWM_BITS (PWM_BITS),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   task automatic model_reset();
      m_data = 8'h00; m_mode = 8'h00; m_div = 16'd0; m_bright = 4'hF;
      m_phase = 1'b1; m_ticks = 0; m_cyc = 0; m_bact = 15; m_out = 8'h00;
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] a);
      logic pon;
      pon = ((m_cyc % PERIOD) < m_bact);
      case (a)
         3'd0:    return {24'd0, m_data};
         3'd2:    return {24'd0, m_mode};
         3'd3:    return {16'd0, m_div};
         3'd6:    return {28'd0, m_bright};
         3'd7:    return {30'd0, pon, m_phase};
         default: return 32'd0;
      endcase
   endfunction

   // Advance one clock: predict the DUT state after the coming edge from the
   // rules (global cycle count gives prescaler and PWM position), then step.
   task automatic cycle();
      logic [7:0] mask, nxt;
      logic       wr, tick;
      int         pos;
      wr   = chipselect && !write_n;
      pos  = m_cyc % PERIOD;
      mask = m_phase ? 8'hFF : ~m_mode;
      nxt  = (pos < m_bact) ? (m_data & mask) : 8'h00;
      tick = ((m_cyc % PRESCALE) == PRESCALE - 1);
      if (m_div == 16'd0) begin
         m_ticks = 0; m_phase = 1'b1;
      end else if (wr && address == 3'd3) begin
         m_ticks = 0;
      end else if (tick) begin
         m_ticks++;
         if (m_ticks == int'(m_div)) begin
            m_ticks = 0; m_phase = ~m_phase;
         end
      end
      m_cyc++;
      if ((m_cyc % PERIOD) == 0) m_bact = int'(m_bright);
      if (wr) begin
         case (address)
            3'd0: m_data = writedata[7:0];
            3'd2: m_mode = writedata[7:0];
            3'd3: m_div = writedata[15:0];
            3'd4: m_data = m_data | writedata[7:0];
            3'd5: m_data = m_data & ~writedata[7:0];
            3'd6: m_bright = writedata[3:0];
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
      m_out = nxt;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      cycle();
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic test_reset();
      if (out_port !== 8'h00) begin
         errors++; $display("FAIL reset_out: got %h expected 00", out_port);
      end
      checks++;
      address = 3'd6; #1;
      if (readdata !== 32'h0000000F) begin
         errors++; $display("FAIL reset_bright: got %h expected 0000000f", readdata);
      end
      checks++;
      address = 3'd7; #1;
      if (readdata !== 32'h00000003) begin
         errors++; $display("FAIL reset_status: got %h expected 00000003", readdata);
      end
      checks++;
      address = 3'd3; #1;
      if (readdata !== 32'h00000000) begin
         errors++; $display("FAIL reset_div: got %h expected 00000000", readdata);
      end
      checks++;
      wr_reg(3'd0, 32'h000000A5);
      if (out_port !== 8'h00) begin
         errors++; $display("FAIL data_latency: got %h expected 00", out_port);
      end
      checks++;
      idle(1);
      if (out_port !== 8'hA5) begin
         errors++; $display("FAIL data_out: got %h expected a5", out_port);
      end
      checks++;
      address = 3'd0; #1;
      if (readdata !== 32'h000000A5) begin
         errors++; $display("FAIL data_read: got %h expected 000000a5", readdata);
      end
      checks++;
   endtask

   task automatic test_set_clear();
      wr_reg(3'd0, 32'h000000A5);
      wr_reg(3'd4, 32'h0000000F);
      address = 3'd0; #1;
      if (readdata !== 32'h000000AF) begin
         errors++; $display("FAIL outset: got %h expected 000000af", readdata);
      end
      checks++;
      wr_reg(3'd5, 32'h00000081);
      address = 3'd0; #1;
      if (readdata !== 32'h0000002E) begin
         errors++; $display("FAIL outclear: got %h expected 0000002e", readdata);
      end
      checks++;
      address = 3'd4; #1;
      if (readdata !== 32'h0) begin
         errors++; $display("FAIL read_outset: got %h expected 0", readdata);
      end
      checks++;
      address = 3'd5; #1;
      if (readdata !== 32'h0) begin
         errors++; $display("FAIL read_outclear: got %h expected 0", readdata);
      end
      checks++;
      idle(1);
      if (out_port !== 8'h2E || out_port !== m_out) begin
         errors++; $display("FAIL setclr_out: got %h expected 2e (model %h)", out_port, m_out);
      end
      checks++;
   endtask

   task automatic test_width_mask();
      logic [7:0] prev;
      wr_reg(3'd0, 32'hFFFFFFFF);
      address = 3'd0; #1;
      if (readdata !== 32'h000000FF) begin
         errors++; $display("FAIL mask_data: got %h expected 000000ff", readdata);
      end
      checks++;
      idle(1);
      prev = out_port;
      if (prev !== 8'hFF) begin
         errors++; $display("FAIL mask_out: got %h expected ff", prev);
      end
      checks++;
      wr_reg(3'd1, 32'h12345678);
      address = 3'd1; #1;
      if (readdata !== 32'h0) begin
         errors++; $display("FAIL rsvd_read: got %h expected 0", readdata);
      end
      checks++;
      idle(2);
      if (out_port !== prev) begin
         errors++; $display("FAIL rsvd_out: got %h expected %h", out_port, prev);
      end
      checks++;
   endtask

   task automatic test_blink();
      logic [7:0] prev;
      int trans, bad;
      wr_reg(3'd0, 32'hFF);
      wr_reg(3'd2, 32'h0F);
      wr_reg(3'd3, 32'd2);
      idle(20);
      trans = 0; bad = 0;
      for (int i = 0; i < 64; i++) begin
         prev = out_port;
         cycle();
         if (out_port !== m_out) begin
            errors++; $display("FAIL blink_model: got %h expected %h", out_port, m_out);
         end
         checks++;
         if (out_port !== prev) trans++;
         if (out_port !== 8'hFF && out_port !== 8'hF0) bad++;
      end
      if (trans != 8) begin
         errors++; $display("FAIL blink_toggles: got %0d expected 8", trans);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL blink_values: got %0d bad cycles expected 0", bad);
      end
      checks++;
      wr_reg(3'd3, 32'd0);
      idle(4);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (out_port !== 8'hFF) bad++;
      end
      if (bad != 0) begin
         errors++; $display("FAIL blink_div0: got %0d non-ff cycles expected 0", bad);
      end
      checks++;
   endtask

   task automatic test_pwm();
      int on, off, guard;
      wr_reg(3'd2, 32'h00);
      wr_reg(3'd0, 32'hFF);
      wr_reg(3'd6, 32'd5);
      idle(30);
      on = 0; off = 0;
      for (int i = 0; i < PERIOD; i++) begin
         cycle();
         if (out_port === 8'hFF) on++;
         if (out_port === 8'h00) off++;
      end
      if (on != 5 || off != 10) begin
         errors++; $display("FAIL pwm_duty5: got on=%0d off=%0d expected on=5 off=10", on, off);
      end
      checks++;
      guard = 0;
      while ((m_cyc % PERIOD) != 7 && guard < 2 * PERIOD) begin
         cycle(); guard++;
      end
      wr_reg(3'd6, 32'd12);
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (out_port !== 8'h00) begin
            errors++; $display("FAIL pwm_shadow: got %h expected 00 at step %0d", out_port, i);
         end
         checks++;
      end
      idle(PERIOD + 2);
      on = 0;
      for (int i = 0; i < PERIOD; i++) begin
         cycle();
         if (out_port !== m_out) begin
            errors++; $display("FAIL pwm_model: got %h expected %h", out_port, m_out);
         end
         checks++;
         if (out_port === 8'hFF) on++;
      end
      if (on != 12) begin
         errors++; $display("FAIL pwm_duty12: got on=%0d expected 12", on);
      end
      checks++;
      wr_reg(3'd6, 32'd0);
      idle(32);
      on = 0;
      for (int i = 0; i < PERIOD; i++) begin
         cycle();
         if (out_port !== 8'h00) on++;
      end
      if (on != 0) begin
         errors++; $display("FAIL pwm_off: got %0d lit cycles expected 0", on);
      end
      checks++;
   endtask

   task automatic test_reset_mid_blink();
      int guard;
      wr_reg(3'd6, 32'hF);
      wr_reg(3'd0, 32'hFF);
      wr_reg(3'd2, 32'h0F);
      wr_reg(3'd3, 32'd2);
      guard = 0;
      while (!(m_phase == 1'b0 && m_out == 8'hF0) && guard < 100) begin
         cycle(); guard++;
      end
      if (out_port !== 8'hF0) begin
         errors++; $display("FAIL midblink_pre: got %h expected f0", out_port);
      end
      checks++;
      #1 reset = 1'b1;
      model_reset();
      #1;
      if (out_port !== 8'h00) begin
         errors++; $display("FAIL midblink_async: got %h expected 00", out_port);
      end
      checks++;
      address = 3'd7; #1;
      if (readdata !== 32'h3) begin
         errors++; $display("FAIL midblink_status: got %h expected 3", readdata);
      end
      checks++;
      @(posedge clk);
      #1 reset = 1'b0;
      address = 3'd0; #1;
      if (readdata !== 32'h0) begin
         errors++; $display("FAIL midblink_data: got %h expected 0", readdata);
      end
      checks++;
      wr_reg(3'd0, 32'hFF);
      wr_reg(3'd2, 32'h0F);
      wr_reg(3'd3, 32'd2);
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (out_port !== m_out) begin
            errors++; $display("FAIL midblink_model: got %h expected %h cycle %0d", out_port, m_out, i);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      logic [2:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) < 3) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd3) d = 32'($urandom_range(0, 3));
            wr_reg(a, d);
         end else begin
            cycle();
         end
         if (out_port !== m_out) begin
            errors++; $display("FAIL rand_out: got %h expected %h iter %0d", out_port, m_out, i);
         end
         checks++;
         address = 3'($urandom_range(0, 7)); #1;
         exp = m_read(address);
         if (readdata !== exp) begin
            errors++; $display("FAIL rand_read: addr %0d got %h expected %h iter %0d", address, readdata, exp, i);
         end
         checks++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      test_reset();
      test_set_clear();
      test_width_mask();
      test_blink();
      test_pwm();
      test_reset_mid_blink();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
